// File: rtl/arb_rr.sv
// arb_rr: round-robin arbiter with registered one-hot grant, lock/hold and binary grant index.
// Optional feature macro: ARB_RR_IDX_EN builds the idx encoder/register; otherwise idx is tied to 0.
`default_nettype none

// Fixed-priority one-hot pick; scans in groups of SPLIT bits, first group wins, then first bit in it.
module pry2oht #(
  parameter int WIDTH     = 9,
  parameter int SPLIT     = 3,
  parameter     DIRECTION = "LSB"
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht
);

  localparam int NG  = (WIDTH + SPLIT - 1) / SPLIT;
  localparam bit REV = (DIRECTION == "MSB");

  logic [WIDTH-1:0] rin;
  logic [WIDTH-1:0] rout;
  logic [NG-1:0]    gany;
  logic [NG-1:0]    gsel;
  logic [NG-1:0]    taken;
  logic             found;

  // "MSB" priority is the "LSB" search on a bit-reversed vector.
  always_comb begin
    rin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rin[i] = REV ? req[WIDTH-1-i] : req[i];
    end
  end

  always_comb begin
    gany  = '0;
    gsel  = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      gany[i/SPLIT] = gany[i/SPLIT] | rin[i];
    end
    for (int g = 0; g < NG; g++) begin
      gsel[g] = gany[g] & ~found;
      found   = found | gany[g];
    end
  end

  always_comb begin
    rout  = '0;
    taken = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rout[i]        = gsel[i/SPLIT] & rin[i] & ~taken[i/SPLIT];
      taken[i/SPLIT] = taken[i/SPLIT] | rin[i];
    end
  end

  always_comb begin
    oht = '0;
    for (int i = 0; i < WIDTH; i++) begin
      oht[i] = REV ? rout[WIDTH-1-i] : rout[i];
    end
  end

endmodule

module arb_rr #(
  parameter int WIDTH     = 9,
  parameter int SPLIT     = 3,
  parameter     DIRECTION = "LSB"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  input  logic                     lck,
  output logic [WIDTH-1:0]         gnt,
  output logic                     vld,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IW  = $clog2(WIDTH);
  localparam bit REV = (DIRECTION == "MSB");

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] msk_nxt;
  logic [WIDTH-1:0] gnt_nxt;
  logic [WIDTH-1:0] req_msk;
  logic [WIDTH-1:0] win_msk;
  logic [WIDTH-1:0] win_raw;
  logic [WIDTH-1:0] win;
  logic             hold;

  assign req_msk = req & msk;

  pry2oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION)) u_pry_msk (
    .req (req_msk),
    .oht (win_msk)
  );

  pry2oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION)) u_pry_raw (
    .req (req),
    .oht (win_raw)
  );

  // Nothing left after the last winner in search order: wrap to the unmasked pick.
  assign win = (|req_msk) ? win_msk : win_raw;
  assign vld = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      msk   <= '1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      msk   <= msk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    msk_nxt   = msk;
    hold      = (state == GRANT) && (|(req & gnt)) && lck;
    if (!hold) begin
      if (|req) begin
        state_nxt = GRANT;
        gnt_nxt   = win;
        // Mask keeps only the bits strictly after the winner in search order.
        msk_nxt   = REV ? (win - WIDTH'(1)) : ~(win | (win - WIDTH'(1)));
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    end
  end

`ifdef ARB_RR_IDX_EN
  logic [IW-1:0] idx_nxt;

  always_comb begin
    idx_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_nxt[i]) begin
        idx_nxt = idx_nxt | IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      idx <= idx_nxt;
    end
  end
`else
  assign idx = '0;
`endif

endmodule

`default_nettype wire

// File: doc/arb_rr.md
# arb_rr

Round-robin arbiter that turns a multi-bit request vector into a registered one-hot grant, plus a binary index of the grant. It reuses `pry2oht` in two places. One instance serves the masked request vector and one serves the unmasked request vector, and a rotating mask makes the priority fair. It sits in front of shared resources (bus ports, FIFO read sides) that need one winner per cycle and stable ownership across multi-cycle transfers.

## Interface
- `WIDTH`, 9: number of requesters, at least 2.
- `SPLIT`, 3: forwarded to the internal `pry2oht` instances.
- `DIRECTION`, "LSB": rotation order. "LSB" searches increasing index, "MSB" searches decreasing index, with wrap-around in both cases.
- `clk`  input  1: clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  WIDTH: request vector, one bit per requester, level-sensitive.
- `lck`  input  1: lock. While high, the current grant is held as long as its request stays high.
- `gnt`  output  WIDTH: registered one-hot grant, all zero when idle.
- `vld`  output  1: registered, equals |gnt.
- `idx`  output  $clog2(WIDTH): registered binary index of the granted requester.

## Operation
- State is held in two registers: `gnt` and the rotating mask `msk`. `msk` marks the bits strictly after the last granted index in search order.
- Two states:
  - IDLE: `vld`=0.
  - GRANT: `vld`=1.
- Next-state decision, evaluated every cycle:
  - HOLD: if `vld` & (`req` & `gnt`)≠0 & `lck`, `gnt` is unchanged.
  - ARBITRATE: otherwise, if `req`≠0, the winner is `pry2oht(req & msk)` if that vector is nonzero, else `pry2oht(req)` (wrap). `gnt` takes the winner and `msk` is recomputed from the winner.
  - RELEASE: otherwise (`req`=0), `gnt`=0 and `vld`=0. `msk` keeps its value, so the round-robin position survives idle periods.
- With `lck` low, the grant rotates every cycle among the active requesters. A lone requester keeps the grant continuously.
- If the holder's request drops while `lck` is high, the arbiter re-arbitrates in that same cycle. There is no idle bubble if any other request is present.
- `idx` is the one-hot-to-binary encoding of the next `gnt` value. It is 0 when `gnt`=0.
- The grant is always one-hot or zero; no two bits are ever set.

## Timing
- Latency: a request asserted at edge N can appear in `gnt` at edge N+1 at the earliest.
- Worst-case wait under full load with `lck` low: WIDTH-1 grants to other requesters.
- All outputs are registered; there is no combinational path from `req`/`lck` to any output.
- Reset values:
  - `gnt`=0, `vld`=0, `idx`=0.
  - `msk`: all ones for "LSB", so index 0 has first priority; all ones for "MSB", so index WIDTH-1 has first priority.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. The first grant after reset follows reset priority.
- `lck` has no effect in IDLE.
- `lck` rising in the same cycle a new grant is issued locks the newly issued grant from the following cycle onward.

## Configuration
- `ARB_RR_IDX_EN`:
  - Defined: the `idx` register and the encoder are built, and `idx` behaves as specified above.
  - Undefined: no `idx` logic is built and `idx` is tied to 0. `gnt`/`vld` behaviour is identical.

## Test plan
- Reset, then `req`=9'b000000000 for 4 cycles -> `gnt`=0, `vld`=0, `idx`=0 every cycle.
- `req`=9'b111111111, `lck`=0, DIRECTION "LSB" -> `gnt` steps through 9'b000000001, 000000010, ..., 100000000, then 000000001. `idx` = 0..8, 0 (with the macro defined).
- `req`=9'b000100100, `lck`=1 -> `gnt`=9'b000000100 and holds for 10 cycles. Dropping `req`[2] -> next cycle `gnt`=9'b000100000.
- Grant at index 5, then `req`=9'b000000001 only -> `gnt`=9'b000000001 next cycle (wrap). Then `req`=0 -> `gnt`=0. Then `req`=9'b000001001 -> `gnt`=9'b000001000, confirming the mask was kept across idle.
- DIRECTION "MSB", `req`=9'b100000011, `lck`=0 -> `gnt` sequence 100000000, 000000010, 000000001, 100000000.
- `rst_n` asserted mid-grant while `lck`=1 -> `gnt`/`vld`/`idx` go to 0 without a clock edge. After release with `req`=9'b111111111 -> first grant is 9'b000000001 ("LSB").
